// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM encodings,
// frame geometry and the word-address helper.
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] CSUM_INIT = 8'h00;

  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [29:0] k);
    return base + {k, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; word_valid pulses
// for one cycle after the fourth byte of a word arrives.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shreg_q, shreg_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  assign last_lane  = (lane_q == LAST_LANE);
  assign word_valid = word_valid_q;
  assign word       = word_q;

  always_comb begin
    lane_d       = lane_q;
    shreg_d      = shreg_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      lane_d  = 2'd0;
      shreg_d = 24'd0;
    end else if (byte_valid) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    shreg_d[7:0]   = byte_data;
        2'd1:    shreg_d[15:8]  = byte_data;
        2'd2:    shreg_d[23:16] = byte_data;
        default: begin
          word_d       = {byte_data, shreg_q};
          word_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q       <= 2'd0;
      shreg_q      <= 24'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      shreg_q      <= shreg_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: frames, packs and checksums a byte
// stream, holding the core in reset until a good image has landed.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR0  | expecting CNT_LO
//   HDR1  | expecting CNT_HI, count is range-checked here
//   DATA  | streaming payload bytes into words
//   CSUM  | expecting the XOR checksum byte
//   DONE  | image good, core released
//   ERR   | framing or checksum failure
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [29:0] word_cnt_q, word_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  csum_q, csum_d;

  logic        accept, arm, data_byte, last_lane;
  logic [15:0] hdr_n;

  assign in_ready  = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign accept    = in_valid && in_ready;
  assign arm       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                               (state_q == ST_ERR));
  assign data_byte = accept && (state_q == ST_DATA);
  assign hdr_n     = {in_data, cnt_lo_q};

  assign core_hold = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);
  assign wr_addr   = addr_q;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (arm),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .last_lane  (last_lane),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    cnt_d      = cnt_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    csum_d     = csum_q;

    if (arm) begin
      state_d    = ST_HDR0;
      word_cnt_d = 30'd0;
      addr_d     = BASE_ADDR;
      csum_d     = CSUM_INIT;
    end else if (accept) begin
      case (state_q)
        ST_HDR0: begin
          cnt_lo_d = in_data;
          state_d  = ST_HDR1;
        end
        ST_HDR1: begin
          cnt_d = hdr_n;
          if (hdr_n == 16'd0)
            state_d = ST_CSUM;
          else if ({16'd0, hdr_n} > 32'(MAX_WORDS))
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
        ST_DATA: begin
          csum_d = csum_q ^ in_data;
          if (last_lane) begin
            // Address is latched with the word so both are stable in the wr_en cycle.
            addr_d     = word_addr(BASE_ADDR, word_cnt_q);
            word_cnt_d = word_cnt_q + 30'd1;
            if (word_cnt_q == ({14'd0, cnt_q} - 30'd1))
              state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_lo_q   <= 8'd0;
      cnt_q      <= 16'd0;
      word_cnt_q <= 30'd0;
      addr_q     <= BASE_ADDR;
      csum_q     <= CSUM_INIT;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      cnt_q      <= cnt_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame-level model predicts writes and
// final status; a per-cycle monitor checks every write against it.
module tb_imem_loader;

  localparam int          MAXW = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, core_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  int errors = 0;
  int checks = 0;

  wr_t  exp_q[$];
  wr_t  got_q[$];
  wr_t  e_cmp;
  logic prev_wr_en = 1'b0;

  imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .core_hold(core_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: every write must match the next predicted write, in order.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back('{wr_addr, wr_data});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, want no write", wr_addr, wr_data);
      end else begin
        e_cmp = exp_q.pop_front();
        check("wr_addr", wr_addr, e_cmp.addr);
        check("wr_data", wr_data, e_cmp.data);
      end
    end
    check("hold_vs_done", {31'd0, core_hold}, {31'd0, ~done});
    if (prev_wr_en && wr_en === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wr_en_width: got 2-cycle pulse, want 1");
    end
    prev_wr_en = (wr_en === 1'b1);
  end

  task automatic make_frame(input wq_t words, input bit bad, output bq_t fr);
    int n;
    logic [7:0] x;
    fr = {};
    n  = words.size();
    x  = 8'h00;
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        fr.push_back(words[i][8*b +: 8]);
        x ^= words[i][8*b +: 8];
      end
    end
    fr.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // Frame-level prediction given how many bytes of the frame get accepted.
  task automatic model_frame(input bq_t fr, input int nsent,
                             output bit ed, output bit ee);
    int n;
    logic [7:0] x;
    ed = 1'b0;
    ee = 1'b0;
    if (nsent < 2) return;
    n = int'(fr[0]) + 256 * int'(fr[1]);
    if (n > MAXW) begin
      ee = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++)
      if (nsent >= 2 + 4*k + 4)
        exp_q.push_back('{BASE + 32'(4*k),
                          {fr[2+4*k+3], fr[2+4*k+2], fr[2+4*k+1], fr[2+4*k]}});
    if (nsent >= 2 + 4*n + 1) begin
      x = 8'h00;
      for (int i = 2; i < 2 + 4*n; i++) x ^= fr[i];
      ed = (fr[2+4*n] == x);
      ee = !ed;
    end
  endtask

  task automatic send_bytes(input bq_t fr, input int nsend, input bit gaps);
    int tries;
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = fr[i];
      tries    = 0;
      while (in_ready !== 1'b1 && tries < 20) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0d never accepted, want in_ready", i);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("arm_in_ready", {31'd0, in_ready}, 32'd1);
    check("arm_core_hold", {31'd0, core_hold}, 32'd1);
    check("arm_done", {31'd0, done}, 32'd0);
    check("arm_error", {31'd0, error}, 32'd0);
  endtask

  task automatic run_frame(input bq_t fr, input bit gaps);
    bit ed, ee;
    model_frame(fr, fr.size(), ed, ee);
    send_bytes(fr, fr.size(), gaps);
    @(negedge clk);
    check("done", {31'd0, done}, {31'd0, ed});
    check("error", {31'd0, error}, {31'd0, ee});
    check("core_hold", {31'd0, core_hold}, {31'd0, !ed});
    check("in_ready_after", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
  endtask

  initial begin
    bq_t fr;
    bit  ed, ee;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // N=2 image from the core's first two instructions.
    got_q = {};
    make_frame('{32'h00500093, 32'h00A00113}, 1'b0, fr);
    check("frame_csum", {24'd0, fr[10]}, 32'h71);
    pulse_start();
    run_frame(fr, 1'b0);
    check("t1_nwrites", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t1_addr0", got_q[0].addr, 32'h0);
      check("t1_data0", got_q[0].data, 32'h00500093);
      check("t1_addr1", got_q[1].addr, 32'h4);
      check("t1_data1", got_q[1].data, 32'h00A00113);
    end
    check("t1_done", {31'd0, done}, 32'd1);

    // Empty image, good and bad checksum.
    got_q = {};
    fr = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    run_frame(fr, 1'b0);
    check("t2_done", {31'd0, done}, 32'd1);
    fr = '{8'h00, 8'h00, 8'h01};
    pulse_start();
    run_frame(fr, 1'b0);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_core_hold", {31'd0, core_hold}, 32'd1);
    check("t23_nwrites", 32'(got_q.size()), 32'd0);

    // Count one past the memory depth.
    got_q = {};
    fr = '{8'(MAXW + 1), 8'h00};
    pulse_start();
    run_frame(fr, 1'b0);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_nwrites", 32'(got_q.size()), 32'd0);

    // Gapped stream for a single word.
    got_q = {};
    make_frame('{32'hDEADBEEF}, 1'b0, fr);
    pulse_start();
    run_frame(fr, 1'b1);
    check("t5_nwrites", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t5_data", got_q[0].data, 32'hDEADBEEF);
    check("t5_done", {31'd0, done}, 32'd1);

    // Reset after header plus first word of an N=2 frame.
    got_q = {};
    make_frame('{32'h11223344, 32'h55667788}, 1'b0, fr);
    pulse_start();
    model_frame(fr, 6, ed, ee);
    send_bytes(fr, 6, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);
    check("t6_pending", 32'(exp_q.size()), 32'd0);
    check("t6_nwrites", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) check("t6_data0", got_q[0].data, 32'h11223344);
    got_q = {};
    make_frame('{32'h01020304, 32'hA5A5A5A5}, 1'b0, fr);
    pulse_start();
    run_frame(fr, 1'b0);
    check("t6b_done", {31'd0, done}, 32'd1);

    // Restart from DONE overwrites from the base address.
    got_q = {};
    make_frame('{32'hCAFEF00D, 32'h00000013, 32'h12345678}, 1'b0, fr);
    pulse_start();
    run_frame(fr, 1'b0);
    check("t7_nwrites", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("t7_addr0", got_q[0].addr, 32'h0);
      check("t7_addr2", got_q[2].addr, 32'h8);
      check("t7_data2", got_q[2].data, 32'h12345678);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
